fg_sequencer: RTL and testbench
===============================

FG_SEQUENCER -- requirements
Module: fg_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): COUNTER_BITWIDTH, 32, period/ON counter width; WAVEFORM_BITWIDTH, 16, slope/amplitude width; PRESCALER_BITWIDTH, 8, clock-enable divider width.
REQ-002 clk_i  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rstn_i  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  start request (level sampled per clk_i); stop_i  in  1  stop request.
REQ-005 prescaler_i  in  PRESCALER_BITWIDTH  enable divider value N; clk_en_o  out  1  one-cycle enable pulse every N+1 clk_i cycles.
REQ-006 cfg_valid_i  in  1 / cfg_ready_o  out  1  configuration handshake.
REQ-007 cfg_period_i, cfg_on_i  in  COUNTER_BITWIDTH each; cfg_k_rise_i, cfg_k_fall_i, cfg_amp_i  in  WAVEFORM_BITWIDTH each  configuration payload.
REQ-008 counter_o, ON_counter_o  out  COUNTER_BITWIDTH; k_rise_o, k_fall_o, amplitude_o  out  WAVEFORM_BITWIDTH  active parameters to waveform generator.
REQ-009 CR_o  out  COUNTER_BITWIDTH  counter register; busy_o  out  1  state != IDLE; period_done_o  out  1  one-cycle wrap pulse.
REQ-010 burst_len_i  in  16, burst_done_o  out  1  (present only with FG_SEQ_BURST_EN).

Function
REQ-011 Prescaler SHALL count 0..prescaler_i and assert clk_en_o for one cycle when count == prescaler_i, then reset to 0; prescaler_i=0 -> clk_en_o high every cycle; prescaler runs only in RUN/STOPPING, held at 0 in IDLE with clk_en_o=0.
REQ-012 FSM states SHALL be IDLE, RUN, STOPPING.
REQ-013 IDLE->RUN on start_i=1; CR_o=0 on entry; pending config, if any, applied on the same edge.
REQ-014 RUN->STOPPING on stop_i=1 (stop_i wins over start_i when simultaneous).
REQ-015 On each clk_en_o in RUN/STOPPING: CR_o==counter_o -> CR_o<=0 and period_done_o<=1 next cycle; else CR_o<=CR_o+1 (no overflow possible since compare precedes increment).
REQ-016 counter_o=0 SHALL hold CR_o at 0 and pulse period_done_o on every clk_en_o.
REQ-017 STOPPING->IDLE on the wrap edge; CR_o SHALL read 0 in IDLE.
REQ-018 Shadow register: cfg_ready_o=1 when shadow empty; cfg_valid_i&cfg_ready_o SHALL capture payload and mark shadow full (cfg_ready_o=0 next cycle).
REQ-019 Full shadow SHALL be copied to active outputs and marked empty on the wrap edge (or immediately in IDLE), so outputs are stable whenever CR_o==0 with clk_en_o=1; active outputs SHALL never change mid-period.
REQ-020 Handshake on the same edge as a transfer of the old shadow: new payload SHALL be accepted only after empty is visible (no same-cycle refill).

Reset
REQ-021 rstn_i low SHALL immediately force: state IDLE, CR_o=0, prescaler count 0, clk_en_o=0, all active/shadow parameters 0, shadow empty (cfg_ready_o=1), busy_o=0, period_done_o=0, burst_done_o=0.
REQ-022 Reset mid-period SHALL discard pending config; no pulse output asserted during or on release of reset.

Configuration
REQ-023 Macro FG_SEQ_BURST_EN defined: burst counter SHALL be loaded from burst_len_i on IDLE->RUN; each wrap decrements; wrap with count==1 -> IDLE and burst_done_o pulses one cycle; burst_len_i=0 means continuous.
REQ-024 Macro undefined: burst_len_i/burst_done_o ports and burst counter absent; RUN continues until stop_i.

Verification
REQ-025 prescaler_i=3, start -> clk_en_o high exactly every 4th clk_i; CR_o 0,1,2,0 with counter_o=2.
REQ-026 Config period=4 written in IDLE, then start, then cfg period=9 mid-period -> counter_o stays 4 until wrap, becomes 9 on the CR_o->0 edge; cfg_ready_o low from capture until that edge.
REQ-027 stop_i at CR_o=1, period=5 -> busy_o stays 1 until CR_o wraps, then IDLE, CR_o=0, one period_done_o pulse.
REQ-028 counter_o=0, prescaler_i=0 -> period_done_o high every cycle after first enable, CR_o constant 0.
REQ-029 rstn_i low at CR_o=3 with shadow full -> all outputs 0, cfg_ready_o=1 asynchronously; after release, no pulses until start.
REQ-030 FG_SEQ_BURST_EN, burst_len_i=3, period=2 -> exactly 3 period_done_o pulses, burst_done_o coincident with third, then IDLE.

Source files
------------

// File: rtl/fg_sequencer_if.sv
// Configuration handshake and payload channel for fg_sequencer.
// Master produces a parameter set; slave holds it in a single-entry shadow register.
interface fg_sequencer_if #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
);
  logic                         cfg_valid_i;
  logic                         cfg_ready_o;
  logic [COUNTER_BITWIDTH-1:0]  cfg_period_i;
  logic [COUNTER_BITWIDTH-1:0]  cfg_on_i;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_rise_i;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_k_fall_i;
  logic [WAVEFORM_BITWIDTH-1:0] cfg_amp_i;

  modport master (
    output cfg_valid_i, cfg_period_i, cfg_on_i, cfg_k_rise_i, cfg_k_fall_i, cfg_amp_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_period_i, cfg_on_i, cfg_k_rise_i, cfg_k_fall_i, cfg_amp_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/fg_sequencer.sv
// Prescaled period sequencer with double-buffered waveform parameters.
// Optional burst mode (fixed number of periods per start) when FG_SEQ_BURST_EN is defined.
module fg_sequencer #(
  parameter int unsigned COUNTER_BITWIDTH   = 32,
  parameter int unsigned WAVEFORM_BITWIDTH  = 16,
  parameter int unsigned PRESCALER_BITWIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  output logic                          clk_en_o,
  fg_sequencer_if.slave                 cfg_if,
  output logic [COUNTER_BITWIDTH-1:0]   counter_o,
  output logic [COUNTER_BITWIDTH-1:0]   ON_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  amplitude_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic                          busy_o,
`ifdef FG_SEQ_BURST_EN
  input  logic [15:0]                   burst_len_i,
  output logic                          burst_done_o,
`endif
  output logic                          period_done_o
);

  localparam int unsigned CW = COUNTER_BITWIDTH;
  localparam int unsigned WW = WAVEFORM_BITWIDTH;
  localparam int unsigned PW = PRESCALER_BITWIDTH;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        r_state;
  logic          r_busy, r_clk_en, r_period_done, r_full, r_ready;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_cr, r_period, r_on, r_sh_period, r_sh_on;
  logic [WW-1:0] r_k_rise, r_k_fall, r_amp, r_sh_k_rise, r_sh_k_fall, r_sh_amp;

  logic w_active, w_start, w_wrap, w_load, w_last, w_exit;

  assign w_active = (r_state != IDLE);
  assign w_start  = start_i && !stop_i;
  assign w_wrap   = w_active && r_clk_en && (r_cr == r_period);
  assign w_load   = r_full && (!w_active || w_wrap);
  assign w_exit   = w_wrap && ((r_state == STOPPING) || w_last);

`ifdef FG_SEQ_BURST_EN
  localparam int unsigned BW = 16;
  logic [BW-1:0] r_burst;
  logic          r_burst_done;

  assign w_last       = w_wrap && (r_burst == BW'(1));
  assign burst_done_o = r_burst_done;

  // Remaining periods in the current burst; zero means run until stopped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_burst      <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= w_last;
      if (!w_active && w_start)
        r_burst <= burst_len_i;
      else if (w_wrap && (r_burst > BW'(1)))
        r_burst <= r_burst - BW'(1);
    end
  end
`else
  assign w_last = 1'b0;
`endif

  // Sequencer state, prescaler and period counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_pre         <= '0;
      r_clk_en      <= 1'b0;
      r_cr          <= '0;
      r_period_done <= 1'b0;
    end else begin
      r_period_done <= w_wrap;

      if (w_active && !w_exit) begin
        if (r_pre == prescaler_i) begin
          r_pre    <= '0;
          r_clk_en <= 1'b1;
        end else begin
          r_pre    <= r_pre + PW'(1);
          r_clk_en <= 1'b0;
        end
      end else begin
        r_pre    <= '0;
        r_clk_en <= 1'b0;
      end

      if (!w_active || w_wrap)
        r_cr <= '0;
      else if (r_clk_en)
        r_cr <= r_cr + CW'(1);

      // A stop request always waits for the current period to finish.
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: if (w_last) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else if (stop_i) begin
          r_state <= STOPPING;
        end
        STOPPING: if (w_wrap) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow register; active set only changes at a period boundary or while idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_full      <= 1'b0;
      r_ready     <= 1'b1;
      r_sh_period <= '0;
      r_sh_on     <= '0;
      r_sh_k_rise <= '0;
      r_sh_k_fall <= '0;
      r_sh_amp    <= '0;
      r_period    <= '0;
      r_on        <= '0;
      r_k_rise    <= '0;
      r_k_fall    <= '0;
      r_amp       <= '0;
    end else if (w_load) begin
      r_full   <= 1'b0;
      r_ready  <= 1'b1;
      r_period <= r_sh_period;
      r_on     <= r_sh_on;
      r_k_rise <= r_sh_k_rise;
      r_k_fall <= r_sh_k_fall;
      r_amp    <= r_sh_amp;
    end else if (cfg_if.cfg_valid_i && r_ready) begin
      r_full      <= 1'b1;
      r_ready     <= 1'b0;
      r_sh_period <= cfg_if.cfg_period_i;
      r_sh_on     <= cfg_if.cfg_on_i;
      r_sh_k_rise <= cfg_if.cfg_k_rise_i;
      r_sh_k_fall <= cfg_if.cfg_k_fall_i;
      r_sh_amp    <= cfg_if.cfg_amp_i;
    end
  end

  assign clk_en_o           = r_clk_en;
  assign CR_o               = r_cr;
  assign busy_o             = r_busy;
  assign period_done_o      = r_period_done;
  assign cfg_if.cfg_ready_o = r_ready;
  assign counter_o          = r_period;
  assign ON_counter_o       = r_on;
  assign k_rise_o           = r_k_rise;
  assign k_fall_o           = r_k_fall;
  assign amplitude_o        = r_amp;

endmodule

// File: tb/tb_fg_sequencer.sv
// Bench for fg_sequencer: directed scenarios plus random traffic against a cycle model.
// Burst checks are included when FG_SEQ_BURST_EN is defined.
module tb_fg_sequencer;
  localparam int unsigned CW = 32;
  localparam int unsigned WW = 16;
  localparam int unsigned PW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [PW-1:0] prescaler_i = '0;
  logic          clk_en_o, busy_o, period_done_o;
  logic [CW-1:0] counter_o, ON_counter_o, CR_o;
  logic [WW-1:0] k_rise_o, k_fall_o, amplitude_o;
`ifdef FG_SEQ_BURST_EN
  logic [15:0]   burst_len_i = '0;
  logic          burst_done_o;
`endif

  fg_sequencer_if #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW)) cfg_if ();

  fg_sequencer #(
    .COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW), .PRESCALER_BITWIDTH(PW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
    .prescaler_i(prescaler_i), .clk_en_o(clk_en_o), .cfg_if(cfg_if.slave),
    .counter_o(counter_o), .ON_counter_o(ON_counter_o), .k_rise_o(k_rise_o),
    .k_fall_o(k_fall_o), .amplitude_o(amplitude_o), .CR_o(CR_o), .busy_o(busy_o),
`ifdef FG_SEQ_BURST_EN
    .burst_len_i(burst_len_i), .burst_done_o(burst_done_o),
`endif
    .period_done_o(period_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a run is tracked as "edges since start"; an enable follows every (N+1)th edge.
  bit          m_run, m_stop, m_en, m_pd, m_bd, m_full;
  int unsigned m_k, m_n, m_burst;
  logic [CW-1:0] m_cr, a_per, a_on, s_per, s_on;
  logic [WW-1:0] a_kr, a_kf, a_amp, s_kr, s_kf, s_amp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_en = 0; m_pd = 0; m_bd = 0; m_full = 0;
    m_k = 0; m_n = 0; m_burst = 0; m_cr = '0;
    a_per = '0; a_on = '0; a_kr = '0; a_kf = '0; a_amp = '0;
    s_per = '0; s_on = '0; s_kr = '0; s_kf = '0; s_amp = '0;
  endtask

  task automatic model_step();
    bit wrap, last, ex;
    int unsigned blen;
`ifdef FG_SEQ_BURST_EN
    blen = burst_len_i;
`else
    blen = 0;
`endif
    wrap = m_run && m_en && (m_cr == a_per);
    last = wrap && (blen >= 0) && (m_burst == 1);
`ifndef FG_SEQ_BURST_EN
    last = 1'b0;
`endif
    ex = wrap && (m_stop || last);
    if (m_full && (!m_run || wrap)) begin
      a_per = s_per; a_on = s_on; a_kr = s_kr; a_kf = s_kf; a_amp = s_amp;
      m_full = 0;
    end else if (cfg_if.cfg_valid_i && !m_full) begin
      s_per = cfg_if.cfg_period_i; s_on = cfg_if.cfg_on_i;
      s_kr = cfg_if.cfg_k_rise_i; s_kf = cfg_if.cfg_k_fall_i; s_amp = cfg_if.cfg_amp_i;
      m_full = 1;
    end
    m_pd = wrap;
    m_bd = last;
    if (m_run) begin
      if (m_en) m_cr = wrap ? '0 : m_cr + 1;
      if (ex) begin
        m_run = 0; m_stop = 0; m_cr = '0; m_en = 0;
      end else begin
        if (stop_i) m_stop = 1;
        if (wrap && m_burst > 1) m_burst--;
        m_k++;
        m_en = ((m_k % (m_n + 1)) == 0);
      end
    end else begin
      m_en = 0; m_cr = '0;
      if (start_i && !stop_i) begin
        m_run = 1; m_stop = 0; m_k = 0; m_n = prescaler_i; m_burst = blen;
      end
    end
  endtask

  task automatic compare_all();
    chk("clk_en", clk_en_o, m_en);
    chk("CR", CR_o, m_cr);
    chk("counter", counter_o, a_per);
    chk("ON_counter", ON_counter_o, a_on);
    chk("k_rise", k_rise_o, a_kr);
    chk("k_fall", k_fall_o, a_kf);
    chk("amplitude", amplitude_o, a_amp);
    chk("busy", busy_o, m_run);
    chk("period_done", period_done_o, m_pd);
    chk("cfg_ready", cfg_if.cfg_ready_o, !m_full);
`ifdef FG_SEQ_BURST_EN
    chk("burst_done", burst_done_o, m_bd);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic send_cfg(input int unsigned p, input int unsigned on, input int unsigned kr,
                          input int unsigned kf, input int unsigned amp);
    cfg_if.cfg_valid_i  = 1'b1;
    cfg_if.cfg_period_i = CW'(p);
    cfg_if.cfg_on_i     = CW'(on);
    cfg_if.cfg_k_rise_i = WW'(kr);
    cfg_if.cfg_k_fall_i = WW'(kf);
    cfg_if.cfg_amp_i    = WW'(amp);
    tick();
    cfg_if.cfg_valid_i  = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int pds, output int bds, output int coinc);
    int n;
    pds = 0; bds = 0; coinc = 0; n = 0;
    while (busy_o && n < max) begin
      tick();
      n++;
      if (period_done_o) pds++;
`ifdef FG_SEQ_BURST_EN
      if (burst_done_o) bds++;
      if (burst_done_o && period_done_o && pds == 3) coinc++;
`endif
    end
    if (n >= max) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_cr(input logic [CW-1:0] v, input int max);
    int n;
    n = 0;
    while (CR_o != v && n < max) begin tick(); n++; end
    if (n >= max) chk("wait_cr_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all();
    rstn_i = 1'b1;
  endtask

  initial begin
    int pds, bds, coinc, ens, nz;
    logic [CW-1:0] prev_cnt;
    cfg_if.cfg_valid_i = 1'b0; cfg_if.cfg_period_i = '0; cfg_if.cfg_on_i = '0;
    cfg_if.cfg_k_rise_i = '0; cfg_if.cfg_k_fall_i = '0; cfg_if.cfg_amp_i = '0;
    model_reset();
    @(negedge clk_i);
    compare_all();
    chk("reset_cfg_ready", cfg_if.cfg_ready_o, 1);
    chk("reset_busy", busy_o, 0);
    rstn_i = 1'b1;
    tick(); tick();

    // Prescaler 3, period 2: enable every 4th cycle, CR 0,1,2,0.
    send_cfg(2, 1, 3, 4, 5);
    tick();
    chk("idle_cfg_applied", counter_o, 2);
    prescaler_i = 8'd3;
    pulse_start();
    ens = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (clk_en_o) ens++;
      if (i == 4)  chk("first_enable", clk_en_o, 1);
      if (i == 5)  chk("cr_step1", CR_o, 1);
      if (i == 9)  chk("cr_step2", CR_o, 2);
      if (i == 13) begin chk("cr_wrap", CR_o, 0); chk("wrap_pulse", period_done_o, 1); end
    end
    chk("enable_count", ens, 4);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    wait_idle(200, pds, bds, coinc);

    // Mid-period reconfiguration only lands on the wrap edge.
    prescaler_i = 8'd0;
    send_cfg(4, 2, 6, 7, 8);
    tick();
    pulse_start();
    tick(); tick();
    send_cfg(9, 3, 1, 1, 1);
    chk("mid_cfg_hold", counter_o, 4);
    chk("mid_cfg_ready_low", cfg_if.cfg_ready_o, 0);
    prev_cnt = counter_o;
    for (int n = 0; n < 20 && !period_done_o; n++) begin prev_cnt = counter_o; tick(); end
    chk("before_wrap_counter", prev_cnt, 4);
    chk("wrap_counter_new", counter_o, 9);
    chk("wrap_ready_back", cfg_if.cfg_ready_o, 1);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    wait_idle(200, pds, bds, coinc);

    // Stop at CR=1 with period 5 finishes the period.
    send_cfg(5, 0, 0, 0, 0);
    tick();
    pulse_start();
    wait_cr(1, 50);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    chk("stop_still_busy", busy_o, 1);
    wait_idle(50, pds, bds, coinc);
    chk("stop_pd_count", pds, 1);
    chk("stop_cr_idle", CR_o, 0);

    // Zero period: CR pinned at 0 and a pulse every enable.
    send_cfg(0, 0, 0, 0, 0);
    tick();
    pulse_start();
    pds = 0; nz = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (period_done_o) pds++;
      if (CR_o != 0) nz++;
    end
    chk("zero_period_pulses", pds, 9);
    chk("zero_period_cr", nz, 0);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    wait_idle(20, pds, bds, coinc);

    // Asynchronous reset mid-period with a pending shadow entry.
    send_cfg(7, 1, 2, 3, 4);
    tick();
    pulse_start();
    send_cfg(6, 1, 1, 1, 1);
    wait_cr(3, 50);
    chk("pre_reset_shadow_full", cfg_if.cfg_ready_o, 0);
    rstn_i = 1'b0;
    #1;
    model_reset();
    chk("async_cr", CR_o, 0);
    chk("async_counter", counter_o, 0);
    chk("async_ready", cfg_if.cfg_ready_o, 1);
    chk("async_busy", busy_o, 0);
    compare_all();
    @(posedge clk_i); @(negedge clk_i);
    compare_all();
    rstn_i = 1'b1;
    ens = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clk_en_o || period_done_o) ens++;
    end
    chk("post_reset_quiet", ens, 0);

`ifdef FG_SEQ_BURST_EN
    // Burst of 3 periods ends by itself.
    send_cfg(2, 0, 0, 0, 0);
    tick();
    burst_len_i = 16'd3;
    pulse_start();
    wait_idle(200, pds, bds, coinc);
    chk("burst_pd_count", pds, 3);
    chk("burst_done_count", bds, 1);
    chk("burst_done_coincident", coinc, 1);
    burst_len_i = 16'd0;
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(599, 0) == 0) do_reset();
      if (!m_run) prescaler_i = PW'($urandom_range(3, 0));
      start_i = ($urandom_range(7, 0) == 0);
      stop_i  = ($urandom_range(15, 0) == 0);
      cfg_if.cfg_valid_i  = ($urandom_range(3, 0) == 0);
      cfg_if.cfg_period_i = CW'($urandom_range(6, 0));
      cfg_if.cfg_on_i     = CW'($urandom);
      cfg_if.cfg_k_rise_i = WW'($urandom);
      cfg_if.cfg_k_fall_i = WW'($urandom);
      cfg_if.cfg_amp_i    = WW'($urandom);
`ifdef FG_SEQ_BURST_EN
      burst_len_i = 16'($urandom_range(3, 0));
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
